// File: rtl/rv_fetch_buf.sv
// Instruction fetch unit: sequential request generator plus an in-order prefetch
// queue, with redirect flush that drops responses to stale in-flight requests.
module rv_fetch_buf #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    input  logic        instr_ready_i
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {S_RESET, S_FETCH, S_FLUSH} state_t;

    state_t        r_state, w_state_nxt;
    logic [63:0]   r_fetch_pc, w_fetch_pc_nxt;
    logic [CW-1:0] r_outstanding, w_outstanding_nxt;
    logic [CW-1:0] r_discard, w_discard_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [PW-1:0] r_head, w_head_nxt;
    logic [PW-1:0] r_tail, w_tail_nxt;
    logic [31:0]   r_q_instr [DEPTH];
    logic [63:0]   r_q_pc    [DEPTH];

    logic          w_req;
    logic          w_grant;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_inflight_nxt;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_rsp_pc;

    // Request cap counts both buffered and in-flight words so the queue cannot overflow.
    assign w_req    = (r_state == S_FETCH) &&
                      (({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C);
    assign w_grant  = w_req & imem_gnt_i;

    // Only one of outstanding/discard is non-zero at a time, so their sum is all in-flight words.
    assign w_inflight     = r_outstanding + r_discard;
    assign w_rsp          = imem_rvalid_i && (w_inflight != '0);
    assign w_inflight_nxt = w_inflight + CW'(w_grant) - CW'(w_rsp);

    assign w_push   = w_rsp && (r_state == S_FETCH) && !redirect_i;
    assign w_pop    = instr_valid_o && instr_ready_i && !redirect_i;
    // Live requests are consecutive words ending just below fetch_pc; the oldest one returns first.
    assign w_rsp_pc = r_fetch_pc - (64'(r_outstanding) << 2);

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;
        w_count_nxt       = r_count;
        w_head_nxt        = r_head;
        w_tail_nxt        = r_tail;
        if (redirect_i) begin
            w_fetch_pc_nxt    = redirect_pc_i & ~64'h3;
            w_outstanding_nxt = '0;
            w_discard_nxt     = w_inflight_nxt;
            w_count_nxt       = '0;
            w_head_nxt        = '0;
            w_tail_nxt        = '0;
            w_state_nxt       = (w_inflight_nxt != '0) ? S_FLUSH : S_FETCH;
        end else begin
            case (r_state)
                S_RESET: w_state_nxt = S_FETCH;
                S_FETCH: begin
                    w_outstanding_nxt = w_inflight_nxt;
                    if (w_grant) w_fetch_pc_nxt = r_fetch_pc + 64'd4;
                    if (w_push)  w_tail_nxt = r_tail + PW'(1);
                    if (w_pop)   w_head_nxt = r_head + PW'(1);
                    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
                end
                S_FLUSH: begin
                    w_discard_nxt = w_inflight_nxt;
                    if (w_inflight_nxt == '0) w_state_nxt = S_FETCH;
                end
                default: w_state_nxt = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_RESET;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            r_count       <= w_count_nxt;
            r_head        <= w_head_nxt;
            r_tail        <= w_tail_nxt;
        end
    end

    // Queue storage carries no reset; the empty-queue output mux hides stale contents.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_instr[r_tail] <= imem_rdata_i;
            r_q_pc[r_tail]    <= w_rsp_pc;
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = (r_count != '0);
    assign instr_o       = instr_valid_o ? r_q_instr[r_head] : NOP;
    assign pc_o          = instr_valid_o ? r_q_pc[r_head] : 64'h0;

endmodule

// File: tb/tb_rv_fetch_buf.sv
// Bench for rv_fetch_buf: in-order memory responder plus a queue-level reference
// model compared every cycle, with directed scenarios and a randomized run.
module tb_rv_fetch_buf;
    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, gnt, rvalid, redir, ready;
    logic [31:0] rdata;
    logic [63:0] rpc;
    logic        req, ivalid;
    logic [63:0] addr, pc;
    logic [31:0] instr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int gnt_prob = 100, rv_prob = 100, mem_lat = 1;

    typedef struct {
        logic [63:0] a;
        int          rdy;
    } mreq_t;
    mreq_t memq[$];

    // Reference model: 0 = reset cycle, 1 = fetching, 2 = draining stale responses.
    int          m_state = 0;
    logic [63:0] m_pc = RST_PC;
    logic [63:0] m_inf[$];
    logic [95:0] m_q[$];
    logic        e_req, e_valid;
    logic [63:0] e_addr, e_pc;
    logic [31:0] e_instr;

    rv_fetch_buf #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .redirect_i(redir), .redirect_pc_i(rpc),
        .instr_valid_o(ivalid), .instr_o(instr), .pc_o(pc),
        .instr_ready_i(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkword(input logic [63:0] a);
        return a[31:0] ^ {a[63:48], 16'h0} ^ 32'h5EED_0003;
    endfunction

    function automatic void model_eval();
        e_req   = (m_state == 1) && ((m_inf.size() + m_q.size()) < DEPTH);
        e_addr  = m_pc;
        e_valid = (m_q.size() != 0);
        e_instr = e_valid ? m_q[0][95:64] : NOP;
        e_pc    = e_valid ? m_q[0][63:0] : 64'h0;
    endfunction

    function automatic void model_edge();
        logic [63:0] p;
        if (rst) begin
            m_state = 0; m_pc = RST_PC; m_q.delete(); m_inf.delete();
        end else if (redir) begin
            if (rvalid && m_inf.size() > 0) void'(m_inf.pop_front());
            if (e_req && gnt) m_inf.push_back(m_pc);
            m_q.delete();
            m_pc = {rpc[63:2], 2'b00};
            m_state = (m_inf.size() > 0) ? 2 : 1;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (e_valid && ready) void'(m_q.pop_front());
            if (rvalid && m_inf.size() > 0) begin
                p = m_inf.pop_front();
                m_q.push_back({rdata, p});
            end
            if (e_req && gnt) begin
                m_inf.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
        end else begin
            if (rvalid && m_inf.size() > 0) void'(m_inf.pop_front());
            if (m_inf.size() == 0) m_state = 1;
        end
    endfunction

    // One clock: model and memory advance on the edge, new memory inputs are driven 1ns later.
    task automatic tick();
        logic        s_req;
        logic [63:0] s_addr;
        s_req  = req;
        s_addr = addr;
        model_eval();
        @(posedge clk);
        model_edge();
        if (rst) memq.delete();
        else begin
            if (rvalid && memq.size() > 0) void'(memq.pop_front());
            if (s_req && gnt) memq.push_back('{s_addr, cyc + mem_lat});
        end
        cyc++;
        #1;
        gnt    = ($urandom_range(99) < gnt_prob);
        rvalid = (memq.size() > 0) && (memq[0].rdy <= cyc) && ($urandom_range(99) < rv_prob);
        rdata  = rvalid ? mkword(memq[0].a) : $urandom;
        model_eval();
    endtask

    task automatic test_reset();
        rst = 1; ready = 1; gnt_prob = 100; rv_prob = 100; mem_lat = 1;
        tick(); tick();
        n_vec++;
        if ({req, addr, ivalid, instr, pc} !== {1'b0, RST_PC, 1'b0, NOP, 64'h0}) begin
            n_err++;
            $display("FAIL reset_hold got req=%b addr=%h vld=%b instr=%h pc=%h, expected 0 %h 0 %h 0",
                     req, addr, ivalid, instr, pc, RST_PC, NOP);
        end
        rst = 0;
        tick();
        n_vec++;
        if ({req, addr, ivalid} !== {1'b1, RST_PC, 1'b0}) begin
            n_err++;
            $display("FAIL reset_first_req got req=%b addr=%h vld=%b, expected 1 %h 0", req, addr, ivalid, RST_PC);
        end
    endtask

    task automatic test_stream();
        int first = -1;
        int nacc = 0;
        logic [63:0] exp_pc = RST_PC;
        rst = 1; ready = 1; gnt_prob = 100; rv_prob = 100; mem_lat = 1;
        tick(); rst = 0;
        for (int i = 1; i <= 40 && nacc < 8; i++) begin
            tick();
            n_vec++;
            if ({req, addr, ivalid, instr, pc} !== {e_req, e_addr, e_valid, e_instr, e_pc}) begin
                n_err++;
                $display("FAIL stream_model cyc=%0d got req=%b addr=%h vld=%b instr=%h pc=%h, expected req=%b addr=%h vld=%b instr=%h pc=%h",
                         cyc, req, addr, ivalid, instr, pc, e_req, e_addr, e_valid, e_instr, e_pc);
            end
            if (ivalid) begin
                if (first < 0) first = i;
                n_vec++;
                if (pc !== exp_pc || instr !== mkword(exp_pc)) begin
                    n_err++;
                    $display("FAIL stream_seq got pc=%h instr=%h, expected pc=%h instr=%h", pc, instr, exp_pc, mkword(exp_pc));
                end
                exp_pc += 64'd4;
                nacc++;
            end
        end
        n_vec++;
        if (first !== 3) begin
            n_err++;
            $display("FAIL stream_latency got %0d cycles, expected 3", first);
        end
        n_vec++;
        if (nacc !== 8) begin
            n_err++;
            $display("FAIL stream_count got %0d accepted, expected 8", nacc);
        end
    endtask

    task automatic test_backpressure();
        int ngr = 0;
        rst = 1; ready = 0; gnt_prob = 100; rv_prob = 100; mem_lat = 1;
        tick(); rst = 0;
        for (int i = 0; i < 10; i++) begin
            if (req && gnt) ngr++;
            tick();
            n_vec++;
            if ({req, addr, ivalid, instr, pc} !== {e_req, e_addr, e_valid, e_instr, e_pc}) begin
                n_err++;
                $display("FAIL bp_model cyc=%0d got req=%b addr=%h vld=%b instr=%h pc=%h, expected req=%b addr=%h vld=%b instr=%h pc=%h",
                         cyc, req, addr, ivalid, instr, pc, e_req, e_addr, e_valid, e_instr, e_pc);
            end
        end
        n_vec++;
        if (ngr !== DEPTH || req !== 1'b0 || ivalid !== 1'b1 || pc !== RST_PC) begin
            n_err++;
            $display("FAIL bp_hold got grants=%0d req=%b vld=%b pc=%h, expected grants=2 req=0 vld=1 pc=%h", ngr, req, ivalid, pc, RST_PC);
        end
        ready = 1;
        tick();
        n_vec++;
        if (pc !== RST_PC + 64'd4 || ivalid !== 1'b1 || req !== 1'b1 || addr !== RST_PC + 64'd8) begin
            n_err++;
            $display("FAIL bp_release got vld=%b pc=%h req=%b addr=%h, expected vld=1 pc=%h req=1 addr=%h",
                     ivalid, pc, req, addr, RST_PC + 64'd4, RST_PC + 64'd8);
        end
    endtask

    task automatic test_gnt_stall();
        rst = 1; ready = 1; gnt_prob = 0; rv_prob = 100; mem_lat = 1;
        tick(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) gnt_prob = 100;
            tick();
            n_vec++;
            if ({req, addr} !== {1'b1, (i < 4) ? RST_PC : RST_PC + 64'd4}) begin
                n_err++;
                $display("FAIL gnt_stall step=%0d got req=%b addr=%h, expected req=1 addr=%h",
                         i, req, addr, (i < 4) ? RST_PC : RST_PC + 64'd4);
            end
        end
    endtask

    task automatic test_redirect_flush();
        int nrv = 0;
        bit found = 0;
        bit seen = 0;
        rst = 1; ready = 1; gnt_prob = 100; rv_prob = 100; mem_lat = 3;
        tick(); rst = 0;
        tick(); tick(); tick();
        n_vec++;
        if (req !== 1'b0) begin
            n_err++;
            $display("FAIL flush_cap got req=%b, expected 0 with two outstanding", req);
        end
        redir = 1; rpc = 64'h2003;
        tick(); redir = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            n_vec++;
            if ({req, addr, ivalid, instr, pc} !== {e_req, e_addr, e_valid, e_instr, e_pc}) begin
                n_err++;
                $display("FAIL flush_model cyc=%0d got req=%b addr=%h vld=%b instr=%h pc=%h, expected req=%b addr=%h vld=%b instr=%h pc=%h",
                         cyc, req, addr, ivalid, instr, pc, e_req, e_addr, e_valid, e_instr, e_pc);
            end
            if (req) begin
                found = 1;
                n_vec++;
                if (addr !== 64'h2000 || nrv !== 2) begin
                    n_err++;
                    $display("FAIL flush_first_req got addr=%h dropped=%0d, expected addr=2000 dropped=2", addr, nrv);
                end
            end else begin
                if (rvalid) nrv++;
                tick();
            end
        end
        if (!found) begin
            n_err++;
            $display("FAIL flush_req_timeout got no request, expected request to 2000");
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ivalid) begin
                seen = 1;
                n_vec++;
                if (pc !== 64'h2000 || instr !== mkword(64'h2000)) begin
                    n_err++;
                    $display("FAIL flush_first_pc got pc=%h instr=%h, expected pc=2000 instr=%h", pc, instr, mkword(64'h2000));
                end
            end
        end
        if (!seen) begin
            n_err++;
            $display("FAIL flush_pc_timeout got no valid, expected pc 2000");
        end
    endtask

    task automatic test_redirect_coincident();
        logic [63:0] first_pc = 64'h0;
        rst = 1; ready = 1; gnt_prob = 100; rv_prob = 100; mem_lat = 1;
        tick(); rst = 0;
        tick(); tick();
        n_vec++;
        if ({rvalid, req, gnt} !== 3'b111) begin
            n_err++;
            $display("FAIL coinc_setup got rvalid=%b req=%b gnt=%b, expected 111", rvalid, req, gnt);
        end
        redir = 1; rpc = 64'h3000;
        tick(); redir = 0;
        for (int i = 0; i < 15; i++) begin
            n_vec++;
            if ({req, addr, ivalid, instr, pc} !== {e_req, e_addr, e_valid, e_instr, e_pc}) begin
                n_err++;
                $display("FAIL coinc_model cyc=%0d got req=%b addr=%h vld=%b instr=%h pc=%h, expected req=%b addr=%h vld=%b instr=%h pc=%h",
                         cyc, req, addr, ivalid, instr, pc, e_req, e_addr, e_valid, e_instr, e_pc);
            end
            if (ivalid) begin
                if (first_pc == 64'h0) first_pc = pc;
                n_vec++;
                if (pc[63:12] !== 52'h3) begin
                    n_err++;
                    $display("FAIL coinc_stale got pc=%h, expected pc in 3000 page", pc);
                end
            end
            tick();
        end
        n_vec++;
        if (first_pc !== 64'h3000) begin
            n_err++;
            $display("FAIL coinc_first_pc got %h, expected 3000", first_pc);
        end
    endtask

    task automatic test_reset_midop();
        bit seen = 0;
        rst = 1; ready = 0; gnt_prob = 100; rv_prob = 100; mem_lat = 2;
        tick(); rst = 0;
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if ({ivalid, pc} !== {1'b1, RST_PC}) begin
            n_err++;
            $display("FAIL midrst_setup got vld=%b pc=%h, expected vld=1 pc=%h", ivalid, pc, RST_PC);
        end
        rst = 1;
        tick(); rst = 0;
        n_vec++;
        if ({req, ivalid, instr, pc, addr} !== {1'b0, 1'b0, NOP, 64'h0, RST_PC}) begin
            n_err++;
            $display("FAIL midrst_outputs got req=%b vld=%b instr=%h pc=%h addr=%h, expected 0 0 %h 0 %h",
                     req, ivalid, instr, pc, addr, NOP, RST_PC);
        end
        ready = 1;
        for (int i = 0; i < 15 && !seen; i++) begin
            tick();
            n_vec++;
            if ({req, addr, ivalid, instr, pc} !== {e_req, e_addr, e_valid, e_instr, e_pc}) begin
                n_err++;
                $display("FAIL midrst_model cyc=%0d got req=%b addr=%h vld=%b instr=%h pc=%h, expected req=%b addr=%h vld=%b instr=%h pc=%h",
                         cyc, req, addr, ivalid, instr, pc, e_req, e_addr, e_valid, e_instr, e_pc);
            end
            if (ivalid) begin
                seen = 1;
                n_vec++;
                if (pc !== RST_PC || instr !== mkword(RST_PC)) begin
                    n_err++;
                    $display("FAIL midrst_restart got pc=%h instr=%h, expected pc=%h instr=%h", pc, instr, RST_PC, mkword(RST_PC));
                end
            end
        end
        if (!seen) begin
            n_err++;
            $display("FAIL midrst_timeout got no valid, expected restart at %h", RST_PC);
        end
    endtask

    task automatic test_random();
        rst = 1; ready = 1;
        tick(); rst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                mem_lat  = $urandom_range(1, 3);
                gnt_prob = $urandom_range(30, 100);
                rv_prob  = $urandom_range(40, 100);
            end
            ready = ($urandom_range(3) != 0);
            redir = ($urandom_range(19) == 0);
            rpc   = ($urandom_range(3) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)} : {$urandom, $urandom};
            rst   = ($urandom_range(299) == 0);
            tick();
            rst = 0; redir = 0;
            n_vec++;
            if ({req, addr, ivalid, instr, pc} !== {e_req, e_addr, e_valid, e_instr, e_pc}) begin
                n_err++;
                $display("FAIL random_model cyc=%0d got req=%b addr=%h vld=%b instr=%h pc=%h, expected req=%b addr=%h vld=%b instr=%h pc=%h",
                         cyc, req, addr, ivalid, instr, pc, e_req, e_addr, e_valid, e_instr, e_pc);
            end
        end
    endtask

    initial begin
        rst = 1; gnt = 0; rvalid = 0; rdata = '0; redir = 0; rpc = '0; ready = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_flush();
        test_redirect_coincident();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion by time limit, expected finish");
        $fatal(1, "time limit");
    end
endmodule
